mo_line_buffer_pp: RTL and testbench

//  Parametrised double-buffered (ping-pong) motion-object horizontal line buffer.

---
 rtl/mo_pkg.sv | 22 ++
 rtl/mo_line_bank.sv | 67 ++++++
 rtl/mo_line_buffer_pp.sv | 126 ++++++++++++
 tb/tb_mo_line_buffer_pp.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mo_pkg.sv
// Shared types for the motion-object line buffer.
// Pixel entry layout, transparent colour and priority-mode encoding.
package mo_pkg;

  localparam int MO_PIX_W = 4;
  localparam int MO_PAL_W = 4;
  localparam int MO_PRI_W = 2;

  localparam logic [MO_PIX_W-1:0] MO_TRANSP = '1;

  typedef struct packed {
    logic [MO_PRI_W-1:0] pri;
    logic [MO_PAL_W-1:0] pal;
    logic [MO_PIX_W-1:0] pix;
  } mo_pix_t;

  typedef enum logic {
    PRI_LAST = 1'b0,
    PRI_GE   = 1'b1
  } pri_mode_e;

endpackage

// File: rtl/mo_line_bank.sv
// One bank of the MO line buffer: DEPTH x {valid,pri,pal,pix}.
// Ports: clk/reset, write port w/ priority compare, comb read port w/ clear.
module mo_line_bank
  import mo_pkg::*;
#(
  parameter int        PIX_W    = MO_PIX_W,
  parameter int        PAL_W    = MO_PAL_W,
  parameter int        PRI_W    = MO_PRI_W,
  parameter int        DEPTH    = 336,
  parameter int        XW       = 9,
  parameter pri_mode_e PRI_MODE = PRI_GE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [XW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_pix,
  input  logic [PAL_W-1:0] wr_pal,
  input  logic [PRI_W-1:0] wr_pri,
  input  logic [XW-1:0]    rd_addr,
  input  logic             rd_clr,
  output logic             rd_hit,
  output logic [PIX_W-1:0] rd_pix,
  output logic [PAL_W-1:0] rd_pal,
  output logic [PRI_W-1:0] rd_pri
);

  localparam int DW = PRI_W + PAL_W + PIX_W;
  localparam logic [XW:0] LIM = (XW+1)'(DEPTH);

  logic [DEPTH-1:0] vld;
  logic [DW-1:0]    mem [DEPTH];
  logic [PRI_W-1:0] cur_pri;
  logic             wr_in;
  logic             rd_in;
  logic             wr_ok;

  assign wr_in   = {1'b0, wr_addr} < LIM;
  assign rd_in   = {1'b0, rd_addr} < LIM;
  assign cur_pri = mem[wr_addr][DW-1 -: PRI_W];

  assign wr_ok = wr_en && wr_in &&
                 (PRI_MODE == PRI_LAST ||
                  !vld[wr_addr] ||
                  wr_pri >= cur_pri);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
    end else begin
      if (rd_clr && rd_in)
        vld[rd_addr] <= 1'b0;
      if (wr_ok)
        vld[wr_addr] <= 1'b1;
    end
  end

  // payload is never reset; the valid bit alone marks an entry live
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_addr] <= {wr_pri, wr_pal, wr_pix};
  end

  assign rd_hit = rd_in && vld[rd_addr];
  assign {rd_pri, rd_pal, rd_pix} = mem[rd_addr];

endmodule

// File: rtl/mo_line_buffer_pp.sv
// Ping-pong MO line buffer between the MO shifter and priority mux.
// Ports: line_start, ld_*, wr_*, rd_en -> rd_valid/rd_pix/rd_pri, wr_bank, wr_drop.
module mo_line_buffer_pp
  import mo_pkg::*;
#(
  parameter int               PIX_W     = MO_PIX_W,
  parameter int               PAL_W     = MO_PAL_W,
  parameter int               PRI_W     = MO_PRI_W,
  parameter int               DEPTH     = 336,
  parameter int               XW        = 9,
  parameter logic [PIX_W-1:0] TRANSP    = '1,
  parameter pri_mode_e        PRI_MODE  = PRI_GE,
  parameter bit               CLR_ON_RD = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_start,
  input  logic                   ld_valid,
  input  logic [XW-1:0]          ld_xpos,
  input  logic                   ld_flip,
  input  logic                   wr_valid,
  input  logic [PIX_W-1:0]       wr_pix,
  input  logic [PAL_W-1:0]       wr_pal,
  input  logic [PRI_W-1:0]       wr_pri,
  input  logic                   rd_en,
  output logic                   rd_valid,
  output logic [PIX_W+PAL_W-1:0] rd_pix,
  output logic [PRI_W-1:0]       rd_pri,
  output logic                   wr_bank,
  output logic                   wr_drop
);

  localparam logic [XW:0] LIM = (XW+1)'(DEPTH);

  logic [XW-1:0]    wptr;
  logic             dir;
  logic [XW:0]      rptr;
  logic [XW-1:0]    wa;
  logic [XW-1:0]    wa_nx;
  logic             wd;
  logic             wr_act;
  logic             rd_act;
  logic             transp;
  logic             clip;
  logic             wr_go;
  logic             r_in;
  logic             rb;
  logic             rd_clr;
  logic             sel_hit;
  logic [1:0]       b_hit;
  logic [PIX_W-1:0] b_pix [2];
  logic [PAL_W-1:0] b_pal [2];
  logic [PRI_W-1:0] b_pri [2];

  // a load in the same cycle as a pixel places that pixel at ld_xpos
  assign wa     = ld_valid ? ld_xpos : wptr;
  assign wd     = ld_valid ? ld_flip : dir;
  assign wa_nx  = wd ? wa - 1'b1 : wa + 1'b1;
  assign wr_act = wr_valid & ~line_start;
  assign rd_act = rd_en & ~line_start;
  assign transp = wr_pix == TRANSP;
  assign clip   = {1'b0, wa} >= LIM;
  assign wr_go  = wr_act & ~transp & ~clip;
  assign r_in   = rptr < LIM;
  assign rb     = ~wr_bank;
  assign rd_clr = rd_act & r_in & CLR_ON_RD;
  assign sel_hit = b_hit[rb] & r_in;

  mo_line_bank #(
    .PIX_W(PIX_W), .PAL_W(PAL_W), .PRI_W(PRI_W),
    .DEPTH(DEPTH), .XW(XW), .PRI_MODE(PRI_MODE)
  ) u_bank0 (
    .clk(clk), .reset(reset),
    .wr_en(wr_go & ~wr_bank), .wr_addr(wa),
    .wr_pix(wr_pix), .wr_pal(wr_pal), .wr_pri(wr_pri),
    .rd_addr(rptr[XW-1:0]), .rd_clr(rd_clr & wr_bank),
    .rd_hit(b_hit[0]), .rd_pix(b_pix[0]),
    .rd_pal(b_pal[0]), .rd_pri(b_pri[0])
  );

  mo_line_bank #(
    .PIX_W(PIX_W), .PAL_W(PAL_W), .PRI_W(PRI_W),
    .DEPTH(DEPTH), .XW(XW), .PRI_MODE(PRI_MODE)
  ) u_bank1 (
    .clk(clk), .reset(reset),
    .wr_en(wr_go & wr_bank), .wr_addr(wa),
    .wr_pix(wr_pix), .wr_pal(wr_pal), .wr_pri(wr_pri),
    .rd_addr(rptr[XW-1:0]), .rd_clr(rd_clr & ~wr_bank),
    .rd_hit(b_hit[1]), .rd_pix(b_pix[1]),
    .rd_pal(b_pal[1]), .rd_pri(b_pri[1])
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank  <= 1'b0;
      wptr     <= '0;
      dir      <= 1'b0;
      rptr     <= '0;
      rd_valid <= 1'b0;
      rd_pix   <= {{PAL_W{1'b0}}, TRANSP};
      rd_pri   <= '0;
      wr_drop  <= 1'b0;
    end else begin
      wptr     <= wr_act ? wa_nx : wa;
      dir      <= wd;
      rd_valid <= rd_act;
      if (line_start) begin
        wr_bank <= ~wr_bank;
        rptr    <= '0;
        // a pixel lost to the swap counts against the new line
        wr_drop <= wr_valid;
      end else begin
        if (rd_act && r_in)
          rptr <= rptr + 1'b1;
        if (wr_act && !transp && clip)
          wr_drop <= 1'b1;
      end
      if (rd_act) begin
        rd_pix <= sel_hit ? {b_pal[rb], b_pix[rb]}
                          : {{PAL_W{1'b0}}, TRANSP};
        rd_pri <= sel_hit ? b_pri[rb] : '0;
      end
    end
  end

endmodule

// File: tb/tb_mo_line_buffer_pp.sv
// Scoreboard bench for mo_line_buffer_pp.
// Behavioural line model predicts every cycle; a monitor compares.
module tb_mo_line_buffer_pp;
  import mo_pkg::*;

  localparam int DEPTH = 336;

  logic       clk = 0;
  logic       reset = 0;
  logic       line_start = 0;
  logic       ld_valid = 0;
  logic [8:0] ld_xpos = 0;
  logic       ld_flip = 0;
  logic       wr_valid = 0;
  logic [3:0] wr_pix = 0;
  logic [3:0] wr_pal = 0;
  logic [1:0] wr_pri = 0;
  logic       rd_en = 0;
  logic       rd_valid;
  logic [7:0] rd_pix;
  logic [1:0] rd_pri;
  logic       wr_bank;
  logic       wr_drop;

  always #5 clk = ~clk;

  mo_line_buffer_pp #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .line_start(line_start),
    .ld_valid(ld_valid), .ld_xpos(ld_xpos), .ld_flip(ld_flip),
    .wr_valid(wr_valid), .wr_pix(wr_pix), .wr_pal(wr_pal),
    .wr_pri(wr_pri), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_pix(rd_pix), .rd_pri(rd_pri), .wr_bank(wr_bank),
    .wr_drop(wr_drop)
  );

  typedef struct {
    bit rv;
    int pix;
    int pri;
    bit drop;
    bit bank;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 0;

  // reference line model: two arrays of pixels indexed by x
  bit mv   [2][DEPTH];
  int mdat [2][DEPTH];
  int mpri [2][DEPTH];
  int mbank, mwptr, mdir, mrptr;
  bit mdrop;
  int epix, epri;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int x = 0; x < DEPTH; x++) mv[b][x] = 0;
    mbank = 0; mwptr = 0; mdir = 0; mrptr = 0;
    mdrop = 0; epix = 'h0F; epri = 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   a, wb, rb;
    bit   ls, wact, ract;
    ls   = line_start;
    wact = wr_valid && !ls;
    ract = rd_en && !ls;
    wb   = mbank;
    rb   = 1 - mbank;
    if (ract) begin
      if (mrptr < DEPTH && mv[rb][mrptr]) begin
        epix = mdat[rb][mrptr];
        epri = mpri[rb][mrptr];
        mv[rb][mrptr] = 0;
      end else begin
        epix = 'h0F;
        epri = 0;
      end
      if (mrptr < DEPTH) mrptr++;
    end
    a = ld_valid ? int'(ld_xpos) : mwptr;
    if (ld_valid) mdir = ld_flip;
    if (wact) begin
      if (wr_pix != 15) begin
        if (a >= DEPTH) mdrop = 1;
        else if (!mv[wb][a] || wr_pri >= mpri[wb][a]) begin
          mv[wb][a]   = 1;
          mdat[wb][a] = wr_pal * 16 + wr_pix;
          mpri[wb][a] = wr_pri;
        end
      end
      a = (a + (mdir ? -1 : 1)) & 511;
    end
    mwptr = a;
    if (ls) begin
      mbank = 1 - mbank;
      mrptr = 0;
      mdrop = wr_valid;
    end
    e.rv = ract; e.pix = epix; e.pri = epri;
    e.drop = mdrop; e.bank = mbank[0];
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    line_start = 0; ld_valid = 0; wr_valid = 0; rd_en = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty got 0 want 1");
      end else begin
        me = q.pop_front();
        chk("rd_valid", rd_valid, me.rv);
        chk("wr_bank", wr_bank, me.bank);
        chk("wr_drop", wr_drop, me.drop);
        if (me.rv) begin
          chk("rd_pix", rd_pix, me.pix);
          chk("rd_pri", rd_pri, me.pri);
        end
      end
    end
  end

  task automatic ls_pulse();
    line_start = 1; tick();
  endtask

  task automatic put(int pix, int pal = 0, int pri = 0);
    wr_valid = 1; wr_pix = 4'(pix);
    wr_pal = 4'(pal); wr_pri = 2'(pri);
    tick();
  endtask

  task automatic ldput(int x, bit f, int pix,
                       int pal = 0, int pri = 0);
    ld_valid = 1; ld_xpos = 9'(x); ld_flip = f;
    put(pix, pal, pri);
  endtask

  task automatic rd(int n);
    repeat (n) begin
      rd_en = 1; tick();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1;
    model_reset();
    mon_on = 1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_pix", rd_pix, 'h0F);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_wr_drop", wr_drop, 0);

    // 1: reset mid-line with data in both banks
    ldput(5, 0, 7, 1, 1); put(8, 2, 0);
    ls_pulse();
    ldput(100, 0, 3, 3, 3);
    rd(8);
    #1 reset = 0;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_pix", rd_pix, 'h0F);
    chk("mid_rst_rd_pri", rd_pri, 0);
    chk("mid_rst_wr_bank", wr_bank, 0);
    model_reset();
    #1 reset = 1;
    ls_pulse(); rd(DEPTH + 2);
    ls_pulse(); rd(DEPTH + 2);

    // 2: ascending object
    ldput(10, 0, 1, 3); put(2, 4); put(3, 5);
    ls_pulse();
    rd(11); chk("t2_x10", rd_pix, 'h31);
    rd(1);  chk("t2_x11", rd_pix, 'h42);
    rd(1);  chk("t2_x12", rd_pix, 'h53);
    rd(DEPTH);
    ls_pulse(); ls_pulse();
    rd(13); chk("t2_reread", rd_pix, 'h0F);
    rd(DEPTH);

    // 3: HFLIP object
    ls_pulse();
    ldput(20, 1, 5); put(6); put(7);
    ls_pulse();
    rd(19); chk("t3_x18", rd_pix, 'h07);
    rd(1);  chk("t3_x19", rd_pix, 'h06);
    rd(1);  chk("t3_x20", rd_pix, 'h05);
    rd(DEPTH);

    // 4: priority compare
    ldput(30, 0, 4, 0, 2); ldput(30, 0, 9, 0, 1);
    ls_pulse();
    ldput(30, 0, 4, 0, 2); ldput(30, 0, 9, 0, 3);
    rd(31); chk("t4_lowpri", rd_pix, 'h04);
    chk("t4_lowpri_pri", rd_pri, 2);
    rd(DEPTH);
    ls_pulse();
    rd(31); chk("t4_hipri", rd_pix, 'h09);
    chk("t4_hipri_pri", rd_pri, 3);
    rd(DEPTH);

    // 5: transparent skip and right-edge clip
    ldput(40, 0, 15);
    chk("t5_transp_nodrop", wr_drop, 0);
    ldput(DEPTH - 1, 0, 2); put(3);
    chk("t5_clip_drop", wr_drop, 1);
    ls_pulse();
    chk("t5_drop_clr", wr_drop, 0);
    rd(41);  chk("t5_x40", rd_pix, 'h0F);
    rd(DEPTH - 41); chk("t5_edge", rd_pix, 'h02);
    rd(2);   chk("t5_sat", rd_pix, 'h0F);

    // 6: collision on line_start, then load+write together
    ld_valid = 1; ld_xpos = 50; wr_valid = 1; wr_pix = 5;
    rd_en = 1; line_start = 1;
    tick();
    chk("t6_drop", wr_drop, 1);
    chk("t6_rd_valid", rd_valid, 0);
    ldput(60, 0, 6);
    ls_pulse();
    rd(51); chk("t6_x50", rd_pix, 'h0F);
    rd(10); chk("t6_x60", rd_pix, 'h06);
    rd(DEPTH);

    // random traffic
    for (int i = 0; i < 5000; i++) begin
      line_start = ($urandom % 80) == 0;
      ld_valid   = ($urandom % 8) == 0;
      ld_xpos    = ($urandom % 4 == 0) ? 9'(325 + $urandom % 20)
                                       : 9'($urandom % 512);
      ld_flip    = 1'($urandom);
      wr_valid   = ($urandom % 3) != 0;
      wr_pix     = ($urandom % 5 == 0) ? 4'hF : 4'($urandom);
      wr_pal     = 4'($urandom);
      wr_pri     = 2'($urandom);
      rd_en      = 1'($urandom);
      tick();
    end

    tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
